// File: rtl/edc_pkg.sv
// Shared definitions for the frame collector.
// Contents: default frame length, error-counter width and the capture FSM
// state encoding used by frame_collector.
package edc_pkg;

  localparam int NDATA_DEFAULT = 128;
  localparam int ERR_W         = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/frame_ram.sv
// Frame sample storage: NDATA x DWIDTH, one write port and one registered
// read port.
// Ports:
//   clk      - clock, all activity on rising edge
//   rst      - asynchronous active-high reset (clears only the read register)
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every edge
//   rd_data  - registered read data, one cycle latency
// A read and a write to the same address in the same cycle returns the old
// contents. The array itself is never reset.
module frame_ram #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int DWIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [NDATA_LOG-1:0] wr_addr,
  input  logic [DWIDTH-1:0]    wr_data,
  input  logic [NDATA_LOG-1:0] rd_addr,
  output logic [DWIDTH-1:0]    rd_data
);

  logic [DWIDTH-1:0] mem [NDATA];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_collector.sv
// Frame collector: captures one aligned frame of NDATA samples indexed by a
// free-running master counter, then holds it for readout until cleared.
// Optional macro: FRAME_COLLECTOR_CHECK_EN enables the index continuity
// checker driving err_cnt; without it err_cnt is constant 0.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   ena         - global enable; low freezes FSM, counters and writes
//   cntin       - sample index from the master counter
//   din         - sample data
//   din_valid   - din/cntin qualify this cycle
//   clr         - one-cycle pulse, abort/release frame (works regardless of ena)
//   rd_addr     - readout address
//   rd_data     - registered readout data, one cycle latency
//   busy        - high while capturing
//   frame_done  - high while a complete frame is held
//   sample_cnt  - samples written this frame, 0..NDATA
//   err_cnt     - continuity errors this frame
//   fsm_state   - debug view of the capture FSM state
// Handshake: a sample is taken on a rising edge when ena && din_valid && !clr
// ("accept"); there is no backpressure, the collector never stalls the source.
module frame_collector
  import edc_pkg::*;
#(
  parameter int NDATA     = NDATA_DEFAULT,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int DWIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NDATA_LOG-1:0] cntin,
  input  logic [DWIDTH-1:0]    din,
  input  logic                 din_valid,
  input  logic                 clr,
  input  logic [NDATA_LOG-1:0] rd_addr,
  output logic [DWIDTH-1:0]    rd_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [NDATA_LOG:0]   sample_cnt,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [1:0]           fsm_state
);

  localparam logic [NDATA_LOG-1:0] LAST_IDX = NDATA_LOG'(NDATA - 1);
  localparam logic [NDATA_LOG:0]   CNT_MAX  = (NDATA_LOG + 1)'(NDATA);

  state_t state;
  logic   accept;
  logic   is_first;
  logic   is_last;
  logic   we;

  assign accept   = ena && din_valid && !clr;
  assign is_first = (cntin == '0);
  assign is_last  = (cntin == LAST_IDX);
  // A frame only starts on index 0; anything else in IDLE is dropped.
  assign we = !rst && accept &&
              (((state == IDLE) && is_first) || (state == CAPTURE));

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sample_cnt <= '0;
    end else if (clr) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sample_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_first) begin
            state      <= CAPTURE;
            busy       <= 1'b1;
            sample_cnt <= (NDATA_LOG + 1)'(1);
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
            if (is_last) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          // Frame is held until clr or rst.
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          sample_cnt <= '0;
        end
      endcase
    end
  end

`ifdef FRAME_COLLECTOR_CHECK_EN
  logic [NDATA_LOG-1:0] exp_idx;
  logic [ERR_W-1:0]     err_q;

  // Expected index follows the last written index + 1, so a single gap
  // counts once and the checker resynchronises on the next sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      exp_idx <= '0;
    end else if (clr) begin
      err_q   <= '0;
    end else if (accept) begin
      if ((state == IDLE) && is_first) begin
        err_q   <= '0;
        exp_idx <= cntin + 1'b1;
      end else if (state == CAPTURE) begin
        if ((cntin != exp_idx) && (err_q != '1)) err_q <= err_q + 1'b1;
        exp_idx <= cntin + 1'b1;
      end
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  frame_ram #(
    .NDATA     (NDATA),
    .NDATA_LOG (NDATA_LOG),
    .DWIDTH    (DWIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (cntin),
    .wr_data (din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_frame_collector.sv
// Directed bench for frame_collector with NDATA=128, DWIDTH=8.
module tb_frame_collector;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [6:0] cntin;
  logic [7:0] din;
  logic       din_valid;
  logic       clr;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       frame_done;
  logic [7:0] sample_cnt;
  logic [7:0] err_cnt;
  logic [1:0] fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FRAME_COLLECTOR_CHECK_EN
  localparam logic [7:0] EXP_ERR_SKIP = 8'd1;
`else
  localparam logic [7:0] EXP_ERR_SKIP = 8'd0;
`endif

  frame_collector #(
    .NDATA  (128),
    .DWIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cntin      (cntin),
    .din        (din),
    .din_valid  (din_valid),
    .clr        (clr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .frame_done (frame_done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [6:0] c, input logic [7:0] d, input logic v);
    cntin     = c;
    din       = d;
    din_valid = v;
    tick();
  endtask

  task automatic check_status(input string tag, input logic b, input logic fd,
                              input logic [7:0] cnt, input logic [1:0] st);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(frame_done), 32'(fd));
    check({tag, "_cnt"},  32'(sample_cnt), 32'(cnt));
    check({tag, "_state"}, 32'(fsm_state), 32'(st));
  endtask

  task automatic read_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
    rd_addr = a;
    din_valid = 1'b0;
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; cntin = '0; din = '0; din_valid = 1'b0;
    clr = 1'b0; rd_addr = '0;
    tick();
    tick();
    // reset state
    check_status("reset", 1'b0, 1'b0, 8'd0, 2'd0);
    check("reset_err", 32'(err_cnt), 32'd0);
    check("reset_rd", 32'(rd_data), 32'd0);
    rst = 1'b0;
    ena = 1'b1;
    tick();

    // start alignment: valid from index 5 is ignored until the counter wraps
    for (int c = 5; c < 128; c++) step(7'(c), 8'(c) ^ 8'hA5, 1'b1);
    check_status("align_wait", 1'b0, 1'b0, 8'd0, 2'd0);

    // full frame with a 10-cycle pause at sample 64
    for (int c = 0; c < 64; c++) begin
      step(7'(c), 8'(c) ^ 8'hA5, 1'b1);
      if (c == 0) check_status("first", 1'b1, 1'b0, 8'd1, 2'd1);
    end
    check_status("pre_pause", 1'b1, 1'b0, 8'd64, 2'd1);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) step(7'd64, 8'hFF, 1'b1);
    check_status("pause", 1'b1, 1'b0, 8'd64, 2'd1);
    ena = 1'b1;
    for (int c = 64; c < 128; c++) begin
      step(7'(c), 8'(c) ^ 8'hA5, 1'b1);
      if (c == 126) check_status("pre_last", 1'b1, 1'b0, 8'd127, 2'd1);
    end
    check_status("full", 1'b0, 1'b1, 8'd128, 2'd2);
    check("full_err", 32'(err_cnt), 32'd0);

    // DONE ignores further samples
    step(7'd0, 8'h00, 1'b1);
    step(7'd64, 8'h00, 1'b1);
    check_status("done_hold", 1'b0, 1'b1, 8'd128, 2'd2);

    // readout of the whole frame
    for (int a = 0; a < 128; a++) read_check("readout", 7'(a), 8'(a) ^ 8'hA5);

    // clr releases the frame
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_status("clr_done", 1'b0, 1'b0, 8'd0, 2'd0);

    // clr wins over the final write at index 127
    for (int c = 0; c < 127; c++) step(7'(c), 8'(c) ^ 8'h3C, 1'b1);
    check_status("pre_clr_last", 1'b1, 1'b0, 8'd127, 2'd1);
    clr = 1'b1;
    step(7'd127, 8'h7F ^ 8'h3C, 1'b1);
    clr = 1'b0;
    check_status("clr_last", 1'b0, 1'b0, 8'd0, 2'd0);
    read_check("clr_mem127", 7'd127, 8'hDA);
    read_check("clr_mem126", 7'd126, 8'h42);

    // asynchronous reset mid-frame at sample 40
    for (int c = 0; c < 40; c++) step(7'(c), 8'(c) ^ 8'h5A, 1'b1);
    check_status("pre_rst", 1'b1, 1'b0, 8'd40, 2'd1);
    cntin = 7'd40; din = 8'h40 ^ 8'h5A; din_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_status("rst_mid", 1'b0, 1'b0, 8'd0, 2'd0);
    check("rst_mid_rd", 32'(rd_data), 32'd0);
    #2 rst = 1'b0;
    for (int c = 0; c < 128; c++) step(7'(c), 8'(c) ^ 8'hA5, 1'b1);
    check_status("after_rst", 1'b0, 1'b1, 8'd128, 2'd2);
    read_check("after_rst_mem39", 7'd39, 8'h27 ^ 8'hA5);

    // clr with ena low still releases
    ena = 1'b0;
    clr = 1'b1;
    step(7'd0, 8'h00, 1'b0);
    clr = 1'b0;
    check_status("clr_no_ena", 1'b0, 1'b0, 8'd0, 2'd0);
    ena = 1'b1;

    // skipped index 50, plus read-during-write on address 10
    rd_addr = 7'd0;
    for (int c = 0; c < 128; c++) begin
      if (c != 50) begin
        if (c == 10) rd_addr = 7'd10;
        step(7'(c), 8'(c) ^ 8'hC3, 1'b1);
        if (c == 10) check("rdw_old", 32'(rd_data), 32'hAF);
        if (c == 11) check("rdw_new", 32'(rd_data), 32'hC9);
      end
    end
    check_status("skip", 1'b0, 1'b1, 8'd127, 2'd2);
    check("skip_err", 32'(err_cnt), 32'(EXP_ERR_SKIP));
    read_check("skip_mem50", 7'd50, 8'h32 ^ 8'hA5);
    read_check("skip_mem51", 7'd51, 8'h33 ^ 8'hC3);

    // error count is cleared by clr
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_err", 32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_collector.md
FRAME_COLLECTOR -- requirements
Module: frame_collector

Interface
REQ-001 Parameter NDATA, default 128, number of samples per frame.
REQ-002 Parameter NDATA_LOG, default $clog2(NDATA), index width.
REQ-003 Parameter DWIDTH, default 8, sample width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ena  in  1  global enable from reset synchronizer; low = pause, no state change except rst/clr.
REQ-007 cntin  in  NDATA_LOG  sample index from master counter.
REQ-008 din  in  DWIDTH  sample data.
REQ-009 din_valid  in  1  din/cntin qualify this cycle.
REQ-010 clr  in  1  one-cycle pulse; abort/release frame, return to IDLE.
REQ-011 rd_addr  in  NDATA_LOG  readout address.
REQ-012 rd_data  out  DWIDTH  readout data, registered.
REQ-013 busy  out  1  high in CAPTURE.
REQ-014 frame_done  out  1  high in DONE.
REQ-015 sample_cnt  out  NDATA_LOG+1  samples written this frame, 0..NDATA.
REQ-016 err_cnt  out  8  continuity errors this frame (only with macro, else tied 0).

Function
REQ-017 FSM states SHALL be IDLE, CAPTURE, DONE; "accept" = ena && din_valid && !clr.
REQ-018 IDLE: accept with cntin==0 SHALL write sample at address 0, sample_cnt<=1, go CAPTURE; accept with cntin!=0 SHALL be ignored.
REQ-019 CAPTURE: each accept SHALL write din at address cntin and increment sample_cnt.
REQ-020 CAPTURE: accept with cntin==NDATA-1 SHALL write and go DONE next cycle (frame_done=1 the cycle after the write).
REQ-021 DONE: SHALL ignore din_valid; no writes; hold sample_cnt, err_cnt.
REQ-022 clr in any state SHALL go IDLE next cycle, zero sample_cnt and err_cnt; same-cycle write suppressed (clr wins); clr acts regardless of ena.
REQ-023 ena low SHALL freeze FSM, counters, memory; rd_data continues to update.
REQ-024 sample_cnt SHALL saturate at NDATA; never wraps.
REQ-025 Read: rd_data SHALL equal mem[rd_addr] sampled at edge, 1-cycle latency, any state; read/write same address same cycle returns old data.
REQ-026 busy and frame_done SHALL be registered and mutually exclusive.

Reset
REQ-027 rst asserted SHALL immediately force IDLE, busy=0, frame_done=0, sample_cnt=0, err_cnt=0, rd_data=0.
REQ-028 Memory contents SHALL NOT be cleared by rst; rst mid-CAPTURE abandons frame, next frame restarts at cntin==0.

Configuration
REQ-029 Macro FRAME_COLLECTOR_CHECK_EN defined: in CAPTURE, accept with cntin != expected (previous written index + 1) SHALL increment err_cnt (saturating at 255); sample still written; expected resyncs to cntin+1.
REQ-030 Macro undefined: no checker logic; err_cnt SHALL be constant 0.

Structure
REQ-031 Shared package edc_pkg SHALL hold NDATA default, state enum (IDLE/CAPTURE/DONE), err_cnt width constant.
REQ-032 Storage SHALL be sub-module frame_ram (1 write port, 1 registered read port, NDATA x DWIDTH); FSM/counters in frame_collector.

Verification
REQ-033 Reset: rst pulse mid-CAPTURE at sample 40 -> busy=0, sample_cnt=0 same cycle; next frame from cntin=0 captures normally.
REQ-034 Full frame: NDATA=128, din=cntin^8'hA5, continuous valid from 0 -> frame_done after write 127, sample_cnt=128; rd_addr 0..127 returns A5^addr one cycle later.
REQ-035 Start alignment: valid begins at cntin=5 -> stays IDLE until cntin wraps to 0, then CAPTURE.
REQ-036 Pause: ena low 10 cycles at sample 64 -> sample_cnt holds 64, no writes; resumes, frame completes with 128.
REQ-037 clr + last write same cycle at cntin=127 -> IDLE, sample_cnt=0, mem[127] unchanged.
REQ-038 With FRAME_COLLECTOR_CHECK_EN: skip cntin 50 (jump 49->51) -> err_cnt=1 at DONE, sample_cnt=127; without macro err_cnt=0.
